// File: rtl/mp3_bus_pkg.sv
// Shared types and constants for the VS1003 serial bus arbiter.
package mp3_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCI_SHIFT,
    ST_SDI_LOAD,
    ST_SDI_SHIFT,
    ST_GAP
  } arb_state_e;

  // Opcode byte that prefixes every SCI register write frame.
  localparam logic [7:0] SCI_WRITE_OP = 8'h02;

  // Cycles with both chip selects high before the bus may be granted again.
  localparam int GAP_CYCLES = 2;

  // Builds the 32-bit SCI write frame: opcode, register address, data.
  function automatic logic [31:0] sci_frame(input logic [7:0] addr, input logic [15:0] data);
    return {SCI_WRITE_OP, addr, data};
  endfunction

endpackage

// File: rtl/spi_shifter.sv
// MSB-first serialiser: each bit is CLK_DIV cycles SCK low, then CLK_DIV
// cycles SCK high. SI only moves on the falling SCK edge, so it is stable
// across every rising edge the decoder samples on.
module spi_shifter
  import mp3_bus_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        width32,
  input  logic [31:0] word,
  output logic        sck,
  output logic        si,
  output logic        done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [31:0] sr_q, sr_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        sck_q, sck_d;
  logic        active_q, active_d;
  logic        div_end;

  // Prescaler, SCK phase and bit countdown; done fires in the last SCK-high cycle.
  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    sck_d     = sck_q;
    active_d  = active_q;
    div_end   = (div_cnt_q == DIV_LAST);
    done      = active_q && sck_q && div_end && (bit_cnt_q == 5'd0);
    if (load) begin
      sr_d      = word;
      bit_cnt_d = width32 ? 5'd31 : 5'd7;
      div_cnt_d = 8'd0;
      sck_d     = 1'b0;
      active_d  = 1'b1;
    end else if (active_q) begin
      if (div_end) begin
        div_cnt_d = 8'd0;
        if (!sck_q) begin
          sck_d = 1'b1;
        end else begin
          // Falling edge: present the next bit (zeros fill in, so SI idles low).
          sck_d = 1'b0;
          sr_d  = {sr_q[30:0], 1'b0};
          if (bit_cnt_q == 5'd0) begin
            active_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q - 5'd1;
          end
        end
      end else begin
        div_cnt_d = div_cnt_q + 8'd1;
      end
    end
  end

  // Shifter state; SI and SCK come straight from flops so reset forces them low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q      <= 32'h0;
      bit_cnt_q <= 5'd0;
      div_cnt_q <= 8'd0;
      sck_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
      active_q  <= active_d;
    end
  end

  assign sck = sck_q;
  assign si  = sr_q[31];

endmodule

// File: rtl/mp3_bus_arbiter.sv
// Shares the VS1003 serial pins between an SCI command port and an SDI
// data port, alternating grants when both are pending and bursting data
// in chunks of at most BURST_BYTES under one XDCS low.
module mp3_bus_arbiter
  import mp3_bus_pkg::*;
#(
  parameter int CLK_DIV     = 1,
  parameter int BURST_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_req,
  input  logic [7:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        cmd_ack,
  input  logic        dat_valid,
  input  logic [7:0]  dat_byte,
  output logic        dat_ready,
  input  logic        DREQ,
  output logic        XCS,
  output logic        XDCS,
  output logic        SCK,
  output logic        SI,
  output logic        busy
);

  localparam logic [7:0] BURST_LAST = 8'(BURST_BYTES);
  localparam logic [1:0] GAP_LAST   = 2'(GAP_CYCLES - 1);

  arb_state_e  state_q, state_d;
  logic        xcs_q, xcs_d;
  logic        xdcs_q, xdcs_d;
  logic        cmd_ack_q, cmd_ack_d;
  logic        last_cmd_q, last_cmd_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic [1:0]  gap_cnt_q, gap_cnt_d;

  logic        sh_load, sh_w32, sh_done;
  logic [31:0] sh_word;
  logic        cmd_win;

  spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (sh_load),
    .width32 (sh_w32),
    .word    (sh_word),
    .sck     (SCK),
    .si      (SI),
    .done    (sh_done)
  );

  // Next-state, chip selects, handshakes and round-robin grant selection.
  always_comb begin
    state_d     = state_q;
    xcs_d       = xcs_q;
    xdcs_d      = xdcs_q;
    cmd_ack_d   = 1'b0;
    last_cmd_d  = last_cmd_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    sh_load     = 1'b0;
    sh_w32      = 1'b0;
    sh_word     = 32'h0;
    // A command loses only when data is also waiting and the previous grant was a command.
    cmd_win     = cmd_req && !(dat_valid && last_cmd_q);
    unique case (state_q)
      ST_IDLE: begin
        if (DREQ && cmd_win) begin
          sh_load    = 1'b1;
          sh_w32     = 1'b1;
          sh_word    = sci_frame(cmd_addr, cmd_data);
          xcs_d      = 1'b0;
          last_cmd_d = 1'b1;
          state_d    = ST_SCI_SHIFT;
        end else if (DREQ && dat_valid) begin
          xdcs_d     = 1'b0;
          last_cmd_d = 1'b0;
          state_d    = ST_SDI_LOAD;
        end
      end
      ST_SCI_SHIFT: begin
        // The ack cycle is spent here with XCS already high, then GAP follows.
        if (cmd_ack_q) begin
          state_d = ST_GAP;
        end else if (sh_done) begin
          xcs_d     = 1'b1;
          cmd_ack_d = 1'b1;
        end
      end
      ST_SDI_LOAD: begin
        if (dat_valid) begin
          sh_load     = 1'b1;
          sh_word     = {dat_byte, 24'h0};
          burst_cnt_d = burst_cnt_q + 8'd1;
          state_d     = ST_SDI_SHIFT;
        end else begin
          xdcs_d  = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_SDI_SHIFT: begin
        if (sh_done) begin
          if ((burst_cnt_q == BURST_LAST) || !DREQ) begin
            xdcs_d  = 1'b1;
            state_d = ST_GAP;
          end else begin
            state_d = ST_SDI_LOAD;
          end
        end
      end
      ST_GAP: begin
        burst_cnt_d = 8'd0;
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = 2'd0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 2'd1;
        end
      end
      default: begin
        xcs_d   = 1'b1;
        xdcs_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and pin registers; reset raises both chip selects immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      xcs_q       <= 1'b1;
      xdcs_q      <= 1'b1;
      cmd_ack_q   <= 1'b0;
      last_cmd_q  <= 1'b0;
      burst_cnt_q <= 8'd0;
      gap_cnt_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      xcs_q       <= xcs_d;
      xdcs_q      <= xdcs_d;
      cmd_ack_q   <= cmd_ack_d;
      last_cmd_q  <= last_cmd_d;
      burst_cnt_q <= burst_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign XCS       = xcs_q;
  assign XDCS      = xdcs_q;
  assign cmd_ack   = cmd_ack_q;
  assign dat_ready = (state_q == ST_SDI_LOAD);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mp3_bus_arbiter.sv
// Bench for mp3_bus_arbiter: bytes/frames seen on SCK rises are queued by a
// pin monitor and compared against values queued when stimulus is driven.
module tb_mp3_bus_arbiter;

  localparam int CLK_DIV     = 1;
  localparam int BURST_BYTES = 32;

  logic        clk, rst, cmd_req, cmd_ack, dat_valid, dat_ready;
  logic        DREQ, XCS, XDCS, SCK, SI, busy;
  logic [7:0]  cmd_addr, dat_byte;
  logic [15:0] cmd_data;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {kind, value}; kind 1 = SCI frame, 2 = SDI byte.
  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];
  int          blen_q[$];
  logic [7:0]  src_q[$];
  bit          src_en = 0;

  int cyc = 0, ack_cnt = 0, ack_cyc = 0, busy_fall_cyc = 0, hs_cnt = 0;
  int last_xcs_len = 0, last_gap = 0, overlap_cnt = 0;

  mp3_bus_arbiter #(.CLK_DIV(CLK_DIV), .BURST_BYTES(BURST_BYTES)) dut (
    .clk(clk), .rst(rst), .cmd_req(cmd_req), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_ack(cmd_ack), .dat_valid(dat_valid), .dat_byte(dat_byte), .dat_ready(dat_ready),
    .DREQ(DREQ), .XCS(XCS), .XDCS(XDCS), .SCK(SCK), .SI(SI), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pin monitor, sampled on the falling clk edge.
  initial begin
    logic [31:0] cmd_sh;
    logic [7:0]  dat_sh;
    int cmd_bits, dat_bits, burst_n, xcs_run, xdcs_hi;
    logic sck_prev, xdcs_prev, busy_prev;
    cmd_sh = 0; dat_sh = 0; cmd_bits = 0; dat_bits = 0; burst_n = 0;
    xcs_run = 0; xdcs_hi = 0; sck_prev = 0; xdcs_prev = 1; busy_prev = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        cmd_bits = 0; dat_bits = 0; burst_n = 0; xcs_run = 0; xdcs_hi = 0;
        sck_prev = 0; xdcs_prev = 1; busy_prev = 0;
      end else begin
        if (SCK && !sck_prev) begin
          if (!XCS) begin
            cmd_sh = {cmd_sh[30:0], SI};
            cmd_bits++;
            if (cmd_bits == 32) begin obs_q.push_back({8'h01, cmd_sh}); cmd_bits = 0; end
          end else if (!XDCS) begin
            dat_sh = {dat_sh[6:0], SI};
            dat_bits++;
            if (dat_bits == 8) begin
              obs_q.push_back({8'h02, 24'h0, dat_sh});
              dat_bits = 0;
              burst_n++;
            end
          end
        end
        sck_prev = SCK;
        if (!XCS) xcs_run++;
        else if (xcs_run != 0) begin last_xcs_len = xcs_run; xcs_run = 0; end
        if (!XDCS) begin
          if (xdcs_hi != 0) begin last_gap = xdcs_hi; xdcs_hi = 0; end
        end else begin
          xdcs_hi++;
          if (!xdcs_prev) begin blen_q.push_back(burst_n); burst_n = 0; end
        end
        xdcs_prev = XDCS;
        if (!XCS && !XDCS) overlap_cnt++;
        if (cmd_ack) begin ack_cnt++; ack_cyc = cyc; end
        if (busy_prev && !busy) busy_fall_cyc = cyc;
        busy_prev = busy;
      end
    end
  end

  // Data source: presents src_q head, pops after each accepted handshake.
  initial begin
    bit hs;
    dat_valid = 1'b0;
    dat_byte  = 8'h00;
    forever begin
      @(negedge clk);
      hs = dat_valid && dat_ready && rst;
      if (hs) hs_cnt++;
      @(posedge clk);
      #2;
      if (hs && src_q.size() > 0) void'(src_q.pop_front());
      if (src_en && src_q.size() > 0) begin dat_valid = 1'b1; dat_byte = src_q[0]; end
      else begin dat_valid = 1'b0; dat_byte = 8'h00; end
    end
  end

  task automatic test_reset();
    rst = 1'b0; cmd_req = 1'b0; cmd_addr = 8'h00; cmd_data = 16'h0000; DREQ = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({XCS, XDCS, SCK, SI, cmd_ack, dat_ready, busy} !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_values got=%b want=1100000",
               {XCS, XDCS, SCK, SI, cmd_ack, dat_ready, busy});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cmd();
    int ack_base;
    bit got;
    logic [39:0] e, o;
    ack_base = ack_cnt;
    exp_q.push_back({8'h01, 32'h020B2020});
    @(posedge clk); #1;
    cmd_addr = 8'h0B; cmd_data = 16'h2020; cmd_req = 1'b1;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (cmd_ack) begin got = 1; cmd_req = 1'b0; end
    end
    checks++;
    if (!got) begin errors++; cmd_req = 1'b0; $display("FAIL cmd_ack_timeout got=none want=pulse"); end
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL cmd_frame got=none want=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL cmd_frame got=%h want=%h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL cmd_extra got=%0d want=0", obs_q.size()); obs_q.delete(); end
    checks++;
    if (last_xcs_len != 64 * CLK_DIV) begin errors++; $display("FAIL cmd_xcs_len got=%0d want=%0d", last_xcs_len, 64 * CLK_DIV); end
    checks++;
    if (ack_cnt - ack_base != 1) begin errors++; $display("FAIL cmd_ack_count got=%0d want=1", ack_cnt - ack_base); end
    checks++;
    if (busy_fall_cyc - ack_cyc != 3) begin errors++; $display("FAIL cmd_busy_after_ack got=%0d want=3", busy_fall_cyc - ack_cyc); end
  endtask

  task automatic test_burst();
    int hs_base, b;
    bit fin;
    logic [39:0] e, o;
    hs_base = hs_cnt;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      src_q.push_back(8'(i));
      exp_q.push_back({8'h02, 24'h0, 8'(i)});
    end
    src_en = 1'b1;
    fin = 0;
    for (int i = 0; i < 3000 && !fin; i++) begin
      @(negedge clk);
      if (src_q.size() == 0 && !busy) fin = 1;
    end
    src_en = 1'b0;
    checks++;
    if (!fin) begin errors++; $display("FAIL burst_timeout got=%0d_left want=0", src_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL burst_byte got=none want=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL burst_byte got=%h want=%h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL burst_extra got=%0d want=0", obs_q.size()); obs_q.delete(); end
    checks++;
    b = (blen_q.size() > 0) ? blen_q.pop_front() : -1;
    if (b != 32) begin errors++; $display("FAIL burst_len1 got=%0d want=32", b); end
    checks++;
    b = (blen_q.size() > 0) ? blen_q.pop_front() : -1;
    if (b != 8) begin errors++; $display("FAIL burst_len2 got=%0d want=8", b); end
    checks++;
    // Two GAP cycles plus the IDLE cycle that samples the next grant.
    if (last_gap != 3) begin errors++; $display("FAIL burst_gap got=%0d want=3", last_gap); end
    checks++;
    if (hs_cnt - hs_base != 40) begin errors++; $display("FAIL burst_handshakes got=%0d want=40", hs_cnt - hs_base); end
    blen_q.delete();
  endtask

  task automatic test_arbitration();
    bit got, fin;
    int b;
    logic [39:0] e, o;
    exp_q.push_back({8'h01, 32'h020A1234});
    for (int i = 0; i < 4; i++) exp_q.push_back({8'h02, 24'h0, 8'(8'h50 + i)});
    exp_q.push_back({8'h01, 32'h020CBEEF});
    overlap_cnt = 0;
    @(posedge clk); #1;
    cmd_addr = 8'h0A; cmd_data = 16'h1234; cmd_req = 1'b1;
    for (int i = 0; i < 4; i++) src_q.push_back(8'(8'h50 + i));
    src_en = 1'b1;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (cmd_ack) begin got = 1; cmd_addr = 8'h0C; cmd_data = 16'hBEEF; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL arb_ack1_timeout got=none want=pulse"); end
    got = 0;
    for (int i = 0; i < 800 && !got; i++) begin
      @(negedge clk);
      if (cmd_ack) got = 1;
    end
    cmd_req = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL arb_ack2_timeout got=none want=pulse"); end
    fin = 0;
    for (int i = 0; i < 200 && !fin; i++) begin
      @(negedge clk);
      if (src_q.size() == 0 && !busy) fin = 1;
    end
    src_en = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL arb_order got=none want=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL arb_order got=%h want=%h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL arb_extra got=%0d want=0", obs_q.size()); obs_q.delete(); end
    checks++;
    b = (blen_q.size() > 0) ? blen_q.pop_front() : -1;
    if (b != 4) begin errors++; $display("FAIL arb_burst_len got=%0d want=4", b); end
    checks++;
    if (overlap_cnt != 0) begin errors++; $display("FAIL arb_cs_overlap got=%0d want=0", overlap_cnt); end
    blen_q.delete();
  endtask

  task automatic test_dreq_drop();
    int hs_base, bad, b;
    bit got, fin;
    logic [39:0] e, o;
    hs_base = hs_cnt;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      src_q.push_back(8'(8'hA0 + i));
      exp_q.push_back({8'h02, 24'h0, 8'(8'hA0 + i)});
    end
    src_en = 1'b1;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (hs_cnt - hs_base >= 3) got = 1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL dreq_byte3_timeout got=%0d want=3", hs_cnt - hs_base); end
    repeat (3) @(negedge clk);
    DREQ = 1'b0;
    repeat (25) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (XDCS !== 1'b1 || XCS !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL dreq_no_grant got=%0d_bad_cycles want=0", bad); end
    checks++;
    b = (blen_q.size() > 0) ? blen_q.pop_front() : -1;
    if (b != 3) begin errors++; $display("FAIL dreq_burst1_len got=%0d want=3", b); end
    DREQ = 1'b1;
    fin = 0;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(negedge clk);
      if (src_q.size() == 0 && !busy) fin = 1;
    end
    src_en = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL dreq_byte got=none want=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL dreq_byte got=%h want=%h", o, e); end
      end
    end
    checks++;
    b = (blen_q.size() > 0) ? blen_q.pop_front() : -1;
    if (b != 3) begin errors++; $display("FAIL dreq_burst2_len got=%0d want=3", b); end
    checks++;
    if (hs_cnt - hs_base != 6) begin errors++; $display("FAIL dreq_handshakes got=%0d want=6", hs_cnt - hs_base); end
    blen_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    int ack_base;
    bit got;
    logic [39:0] e, o;
    ack_base = ack_cnt;
    exp_q.push_back({8'h01, 32'h020B2020});
    @(posedge clk); #1;
    cmd_addr = 8'h0B; cmd_data = 16'h2020; cmd_req = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (!XCS) got = 1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rstmid_grant_timeout got=XCS_high want=XCS_low"); end
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({XCS, SCK, SI, cmd_ack} !== 4'b1000) begin
      errors++;
      $display("FAIL rstmid_async got=%b want=1000", {XCS, SCK, SI, cmd_ack});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ack_cnt != ack_base) begin errors++; $display("FAIL rstmid_ack_in_reset got=%0d want=0", ack_cnt - ack_base); end
    rst = 1'b1;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (cmd_ack) begin got = 1; cmd_req = 1'b0; end
    end
    cmd_req = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL rstmid_ack_timeout got=none want=pulse"); end
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL rstmid_frame got=none want=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL rstmid_frame got=%h want=%h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_extra got=%0d want=0", obs_q.size()); obs_q.delete(); end
    checks++;
    if (last_xcs_len != 64 * CLK_DIV) begin errors++; $display("FAIL rstmid_xcs_len got=%0d want=%0d", last_xcs_len, 64 * CLK_DIV); end
    checks++;
    if (ack_cnt - ack_base != 1) begin errors++; $display("FAIL rstmid_ack_count got=%0d want=1", ack_cnt - ack_base); end
  endtask

  initial begin
    test_reset();
    test_cmd();
    test_burst();
    test_arbitration();
    test_dreq_drop();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mp3_bus_arbiter.md
# mp3_bus_arbiter

Owns the serial pins of the VS1003 MP3 decoder and shares them between two requesters: a command port (SCI register writes, e.g. volume or mode) and a data port (SDI byte stream). It serialises one requester at a time onto SCK/SI, drives XCS or XDCS, honours DREQ flow control, and bursts data in DREQ-sized chunks. It sits between `mp3board`'s sequencing logic and the board pins in the 2 MHz domain.

## Interface
- `CLK_DIV`, 1: SCK half-period in `clk` cycles; SCK = clk/(2·CLK_DIV); legal range 1..255
- `BURST_BYTES`, 32: maximum SDI bytes per XDCS-low burst; legal range 1..255
- `clk` in 1: single clock (2 MHz in the design)
- `rst` in 1: reset, asynchronous, active-low
- `cmd_req` in 1: SCI write request; held high until `cmd_ack`
- `cmd_addr` in 8: SCI register address; sampled at grant
- `cmd_data` in 16: SCI write data; sampled at grant
- `cmd_ack` out 1: one-cycle pulse, command frame complete
- `dat_valid` in 1: `dat_byte` is valid
- `dat_byte` in 8: next SDI byte
- `dat_ready` out 1: load strobe; byte consumed when `dat_valid && dat_ready`
- `DREQ` in 1: decoder can accept data/commands
- `XCS`, `XDCS` out 1 each: SCI/SDI chip selects, active-low
- `SCK`, `SI` out 1 each: serial clock, serial data (MSB first)
- `busy` out 1: high in any state except IDLE

## Operation
- States: IDLE, SCI_SHIFT, SDI_LOAD, SDI_SHIFT, GAP.
- IDLE: grant only when `DREQ`=1.
  - Both requests pending: command wins unless the last grant was a command. Data bursts and commands then alternate, so neither starves.
  - Grant to command: latch the frame {8'h02, cmd_addr, cmd_data} (32 bits), then go to SCI_SHIFT.
  - Grant to data: go to SDI_LOAD.
  - `cmd_req` dropped before grant withdraws the request.
- SCI_SHIFT: XCS=0. Shift 32 bits, then XCS=1, pulse `cmd_ack`, go to GAP.
- SDI_LOAD: XDCS=0, `dat_ready`=1 for exactly one cycle.
  - If `dat_valid`: load `dat_byte`, increment the burst count, go to SDI_SHIFT.
  - Otherwise: end the burst and go to GAP.
- SDI_SHIFT: after 8 bits, the burst ends (XDCS=1, go to GAP) if the count equals `BURST_BYTES` or `DREQ`=0. Otherwise return to SDI_LOAD with XDCS held low.
- GAP: both chip selects high for exactly 2 cycles, then IDLE. The burst count clears.
- Bit engine: SI changes only while SCK is low; the decoder samples on the SCK rising edge. Each bit is CLK_DIV cycles SCK low, then CLK_DIV cycles SCK high.
- XCS and XDCS are never low simultaneously.

## Timing
- Reset values: XCS=1, XDCS=1, SCK=0, SI=0, cmd_ack=0, dat_ready=0, busy=0.
- Async reset mid-frame: chip selects rise immediately, the frame is abandoned, and no `cmd_ack` is issued.
- Grant latency: the chip select falls on the clock edge after IDLE samples request && DREQ.
  - First SI bit is valid in that same cycle.
  - First SCK rise comes CLK_DIV cycles later.
- Command frame: XCS is low for exactly 64·CLK_DIV cycles. `cmd_ack` is high during the first cycle with XCS=1.
- Data byte: 16·CLK_DIV cycles, plus 1 SDI_LOAD cycle between bytes (SCK low throughout SDI_LOAD).
- DREQ falling mid-frame or mid-byte: the current frame or byte completes. For SDI, the burst then ends.
- Counters: the bit counter is 5 bits, the burst counter 8 bits. Neither may wrap; both clear in GAP.

## Structure
- Package `mp3_bus_pkg` holds:
  - the state enum
  - `SCI_WRITE_OP` = 8'h02
  - `GAP_CYCLES` = 2
- Sub-module `spi_shifter`:
  - Inputs: load, width (8/32), 32-bit word.
  - Outputs: SCK, SI, done pulse.
  - Owns the CLK_DIV prescaler and bit counter.
- The arbiter FSM owns the chip selects, the handshakes and round-robin fairness.

## Test plan
- CLK_DIV=1, DREQ=1, cmd_req with addr 0x0B, data 0x2020:
  - SI sampled on 32 SCK rises = 0x020B2020.
  - XCS low for 64 cycles.
  - One `cmd_ack` pulse; busy falls 3 cycles after ack.
- 40 bytes 0x00..0x27 with `dat_valid` always high, BURST_BYTES=32:
  - First burst carries 0x00..0x1F under one XDCS low.
  - Then 2-cycle gap, then a second burst of 0x20..0x27.
  - Exactly 40 `dat_ready && dat_valid` cycles.
- cmd_req and dat_valid asserted together from IDLE:
  - Command frame first, then a data burst, then a second pending command.
  - XCS and XDCS are never both low.
- DREQ dropped mid-byte 3 of a burst: byte 3 completes intact, XDCS rises, and no new grant until DREQ returns high.
- `rst` driven low 10 cycles into a command frame:
  - XCS=1, SCK=0, SI=0 asynchronously.
  - No `cmd_ack`.
  - After release, the held `cmd_req` restarts the full frame from bit 31.
